rv32_decode_stage: RTL and testbench

//  Decode stage sitting between fetch and execute; directly upstream of the 32x32 register file.

---
 rtl/rv32_pkg.sv | 78 +++++++
 rtl/rv32_decode_stage_if.sv | 27 ++
 rtl/rv32_imm_gen.sv | 23 ++
 rtl/rv32_decode_stage.sv | 162 ++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, opclass codes, field positions and
// the opcode-level decode helper used by the decode stage.
package rv32_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    // Opclass 0 is reserved for the empty/reset ID/EX register.
    localparam logic [3:0] CLS_NONE    = 4'd0;
    localparam logic [3:0] CLS_ALU     = 4'd1;
    localparam logic [3:0] CLS_ALU_IMM = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_JAL     = 4'd6;
    localparam logic [3:0] CLS_JALR    = 4'd7;
    localparam logic [3:0] CLS_LUI     = 4'd8;
    localparam logic [3:0] CLS_AUIPC   = 4'd9;
    localparam logic [3:0] CLS_SYSTEM  = 4'd10;
    localparam logic [3:0] CLS_ILL     = 4'd15;

    localparam int RD_LSB   = 7;
    localparam int F3_LSB   = 12;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int F7B5_BIT = 30;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0] opclass;
        imm_fmt_e   fmt;
        logic       use_rs1;
        logic       use_rs2;
        logic       writes_rd;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode_opcode(input logic [6:0] opcode);
        dec_t d;
        d.opclass   = CLS_ILL;
        d.fmt       = FMT_R;
        d.use_rs1   = 1'b0;
        d.use_rs2   = 1'b0;
        d.writes_rd = 1'b0;
        d.illegal   = 1'b0;
        case (opcode)
            OPCODE_OP:     begin d.opclass = CLS_ALU;     d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.writes_rd = 1'b1; end
            OPCODE_OP_IMM: begin d.opclass = CLS_ALU_IMM; d.fmt = FMT_I; d.use_rs1 = 1'b1; d.writes_rd = 1'b1; end
            OPCODE_LOAD:   begin d.opclass = CLS_LOAD;    d.fmt = FMT_I; d.use_rs1 = 1'b1; d.writes_rd = 1'b1; end
            OPCODE_STORE:  begin d.opclass = CLS_STORE;   d.fmt = FMT_S; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OPCODE_BRANCH: begin d.opclass = CLS_BRANCH;  d.fmt = FMT_B; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OPCODE_JAL:    begin d.opclass = CLS_JAL;     d.fmt = FMT_J; d.writes_rd = 1'b1; end
            OPCODE_JALR:   begin d.opclass = CLS_JALR;    d.fmt = FMT_I; d.use_rs1 = 1'b1; d.writes_rd = 1'b1; end
            OPCODE_LUI:    begin d.opclass = CLS_LUI;     d.fmt = FMT_U; d.writes_rd = 1'b1; end
            OPCODE_AUIPC:  begin d.opclass = CLS_AUIPC;   d.fmt = FMT_U; d.writes_rd = 1'b1; end
            OPCODE_SYSTEM: begin d.opclass = CLS_SYSTEM;  d.fmt = FMT_I; d.use_rs1 = 1'b1; d.writes_rd = 1'b1; end
            default:       d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv32_decode_stage_if.sv
// ID/EX output bus of the decode stage: registered instruction fields towards
// execute, with execute returning id_ready.
interface rv32_decode_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_op1;
    logic [31:0] id_op2;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic        id_f7b5;
    logic [3:0]  id_opclass;
    logic        id_illegal;

    modport master (
        output id_valid, id_pc, id_op1, id_op2, id_imm, id_rd,
               id_funct3, id_f7b5, id_opclass, id_illegal,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_pc, id_op1, id_op2, id_imm, id_rd,
               id_funct3, id_f7b5, id_opclass, id_illegal,
        output id_ready
    );
endinterface

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate generator; takes instr[31:7] and the format
// selected by the opcode decode, returns the sign-extended immediate.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] bits,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{bits[31]}}, bits[31:20]};
            FMT_S:   imm = {{20{bits[31]}}, bits[31:25], bits[11:7]};
            FMT_B:   imm = {{19{bits[31]}}, bits[31], bits[7], bits[30:25], bits[11:8], 1'b0};
            FMT_U:   imm = {bits[31:12], 12'b0};
            FMT_J:   imm = {{11{bits[31]}}, bits[31], bits[19:12], bits[20], bits[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: one-entry instruction slot feeding the ID/EX register.
// DECODE_FWD_EN enables ex/wb bypass; otherwise any pending write stalls.
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter int          XLEN   = 32,
    parameter logic [31:0] RST_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wen,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_wen,
    input  logic [XLEN-1:0] wb_data,
    rv32_decode_stage_if.master idex
);

    logic        slot_full_reg;
    logic [31:0] slot_instr_reg;
    logic [31:0] slot_pc_reg;

    logic        id_valid_reg;
    logic [31:0] id_pc_reg;
    logic [31:0] id_op1_reg;
    logic [31:0] id_op2_reg;
    logic [31:0] id_imm_reg;
    logic [4:0]  id_rd_reg;
    logic [2:0]  id_funct3_reg;
    logic        id_f7b5_reg;
    logic [3:0]  id_opclass_reg;
    logic        id_illegal_reg;

    dec_t        dec;
    logic [31:0] imm;
    logic        stall;
    logic        advance;
    logic        id_free;

    assign dec = decode_opcode(slot_instr_reg[6:0]);

    rv32_imm_gen u_imm_gen (
        .bits (slot_instr_reg[31:7]),
        .fmt  (dec.fmt),
        .imm  (imm)
    );

    // Source 0 is rs1, source 1 is rs2; unused fields neither stall nor bypass.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [4:0]  rs;
        logic        used;
        logic [31:0] rf_val;
        logic [31:0] op_val;
        logic        hazard;

        assign rs     = slot_instr_reg[(gi == 0 ? RS1_LSB : RS2_LSB) +: 5];
        assign used   = (gi == 0) ? dec.use_rs1 : dec.use_rs2;
        assign rf_val = (gi == 0) ? rf_rdata1 : rf_rdata2;

`ifdef DECODE_FWD_EN
        always_comb begin
            op_val = rf_val;
            hazard = 1'b0;
            if (used) begin
                if (rs == 5'd0)
                    op_val = '0;
                else if (ex_wen && !ex_is_load && ex_rd == rs)
                    op_val = ex_result;
                else if (wb_wen && wb_rd == rs)
                    op_val = wb_data;
                hazard = ex_is_load && ex_wen && (rs != 5'd0) && (ex_rd == rs);
            end
        end
`else
        assign op_val = rf_val;
        assign hazard = used && (rs != 5'd0) &&
                        ((ex_wen && ex_rd == rs) || (wb_wen && wb_rd == rs));
`endif
    end

`ifndef DECODE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_result, wb_data, ex_is_load};
`endif

    assign rf_rs1   = g_src[0].rs;
    assign rf_rs2   = g_src[1].rs;
    assign stall    = slot_full_reg && (g_src[0].hazard || g_src[1].hazard);
    assign id_free  = !id_valid_reg || idex.id_ready;
    assign advance  = slot_full_reg && id_free && !stall && !flush;
    assign if_ready = !slot_full_reg || advance;

    // Flush wins over capture, so an instruction offered in the flush cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full_reg  <= 1'b0;
            slot_instr_reg <= '0;
            slot_pc_reg    <= '0;
        end else if (flush) begin
            slot_full_reg  <= 1'b0;
        end else if (if_valid && if_ready) begin
            slot_full_reg  <= 1'b1;
            slot_instr_reg <= if_instr;
            slot_pc_reg    <= if_pc;
        end else if (advance) begin
            slot_full_reg  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_reg   <= 1'b0;
            id_pc_reg      <= RST_PC;
            id_op1_reg     <= '0;
            id_op2_reg     <= '0;
            id_imm_reg     <= '0;
            id_rd_reg      <= '0;
            id_funct3_reg  <= '0;
            id_f7b5_reg    <= 1'b0;
            id_opclass_reg <= CLS_NONE;
            id_illegal_reg <= 1'b0;
        end else if (flush) begin
            id_valid_reg   <= 1'b0;
        end else if (advance) begin
            id_valid_reg   <= 1'b1;
            id_pc_reg      <= slot_pc_reg;
            id_op1_reg     <= g_src[0].op_val;
            id_op2_reg     <= g_src[1].op_val;
            id_imm_reg     <= imm;
            id_rd_reg      <= dec.writes_rd ? slot_instr_reg[RD_LSB +: 5] : 5'd0;
            id_funct3_reg  <= slot_instr_reg[F3_LSB +: 3];
            id_f7b5_reg    <= slot_instr_reg[F7B5_BIT];
            id_opclass_reg <= dec.opclass;
            id_illegal_reg <= dec.illegal;
        end else if (idex.id_ready) begin
            id_valid_reg   <= 1'b0;
        end
    end

    assign idex.id_valid   = id_valid_reg;
    assign idex.id_pc      = id_pc_reg;
    assign idex.id_op1     = id_op1_reg;
    assign idex.id_op2     = id_op2_reg;
    assign idex.id_imm     = id_imm_reg;
    assign idex.id_rd      = id_rd_reg;
    assign idex.id_funct3  = id_funct3_reg;
    assign idex.id_f7b5    = id_f7b5_reg;
    assign idex.id_opclass = id_opclass_reg;
    assign idex.id_illegal = id_illegal_reg;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Scoreboard bench for rv32_decode_stage: directed cases then random traffic,
// checked against an instruction-level reference model.
module tb_rv32_decode_stage;
    import rv32_pkg::*;

    localparam logic [31:0] TB_RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, flush;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rf_rs1, rf_rs2, ex_rd, wb_rd;
    logic [31:0] rf_rdata1, rf_rdata2, ex_result, wb_data;
    logic        ex_wen, ex_is_load, wb_wen, id_ready;
    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    rv32_decode_stage_if idex ();
    assign idex.id_ready = id_ready;
    assign rf_rdata1 = rf_mem[rf_rs1];
    assign rf_rdata2 = rf_mem[rf_rs2];

    rv32_decode_stage #(.XLEN(32), .RST_PC(TB_RST_PC)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_result(ex_result),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data), .idex(idex)
    );

    typedef struct packed {
        logic [31:0] pc, op1, op2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7b5;
        logic [3:0]  cls;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [3:0]  cls;
        bit          ill, u1, u2, wr;
        logic [31:0] imm;
    } ref_t;

    typedef struct { logic [31:0] instr, pc; } slot_t;

    exp_t  sb[$];
    slot_t slot_q[$];
    bit    m_id_valid = 0;
    bit    exp_id_valid, exp_if_ready;
    bit    mon_en = 0;
    int    n_checks = 0, n_errors = 0, n_txn = 0;

    // Immediates built arithmetically from sign and field values.
    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t r;
        int s, hi;
        s  = $signed(ins);
        hi = (s < 0) ? -1 : 0;
        r.cls = CLS_ILL; r.ill = 0; r.u1 = 0; r.u2 = 0; r.wr = 0; r.imm = 0;
        case (ins[6:0])
            7'h33: begin r.cls = CLS_ALU;     r.u1 = 1; r.u2 = 1; r.wr = 1; end
            7'h13: begin r.cls = CLS_ALU_IMM; r.u1 = 1; r.wr = 1; r.imm = s >>> 20; end
            7'h03: begin r.cls = CLS_LOAD;    r.u1 = 1; r.wr = 1; r.imm = s >>> 20; end
            7'h67: begin r.cls = CLS_JALR;    r.u1 = 1; r.wr = 1; r.imm = s >>> 20; end
            7'h73: begin r.cls = CLS_SYSTEM;  r.u1 = 1; r.wr = 1; r.imm = s >>> 20; end
            7'h23: begin r.cls = CLS_STORE;   r.u1 = 1; r.u2 = 1;
                         r.imm = (s >>> 25) * 32 + int'(ins[11:7]); end
            7'h63: begin r.cls = CLS_BRANCH;  r.u1 = 1; r.u2 = 1;
                         r.imm = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
            7'h6F: begin r.cls = CLS_JAL;     r.wr = 1;
                         r.imm = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
            7'h37: begin r.cls = CLS_LUI;     r.wr = 1; r.imm = ins & 32'hFFFF_F000; end
            7'h17: begin r.cls = CLS_AUIPC;   r.wr = 1; r.imm = ins & 32'hFFFF_F000; end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    function automatic bit src_blocked(input bit used, input logic [4:0] rs);
        if (!used || rs == 0) return 0;
`ifdef DECODE_FWD_EN
        return ex_is_load && ex_wen && ex_rd == rs;
`else
        return (ex_wen && ex_rd == rs) || (wb_wen && wb_rd == rs);
`endif
    endfunction

    function automatic logic [31:0] src_value(input bit used, input logic [4:0] rs);
`ifdef DECODE_FWD_EN
        if (used) begin
            if (rs == 0) return 0;
            if (ex_wen && !ex_is_load && ex_rd == rs) return ex_result;
            if (wb_wen && wb_rd == rs) return wb_data;
        end
`endif
        return rf_mem[rs];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
            9: w[6:0] = 7'h73;  default: w[6:0] = 7'h7F;
        endcase
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic step();
        slot_t s;
        ref_t  r;
        exp_t  e;
        bit    full, free, stall, adv;
        full  = slot_q.size() != 0;
        free  = !m_id_valid || id_ready;
        stall = 0;
        if (full) begin
            s = slot_q[0];
            r = ref_decode(s.instr);
            stall = src_blocked(r.u1, s.instr[19:15]) || src_blocked(r.u2, s.instr[24:20]);
        end
        adv = full && free && !stall && !flush;
        exp_id_valid = m_id_valid;
        exp_if_ready = !full || adv;
        if (rst || flush) begin
            slot_q.delete();
            sb.delete();
            m_id_valid = 0;
        end else begin
            if (adv) begin
                e.pc   = s.pc;
                e.op1  = src_value(r.u1, s.instr[19:15]);
                e.op2  = src_value(r.u2, s.instr[24:20]);
                e.imm  = r.imm;
                e.rd   = r.wr ? s.instr[11:7] : 5'd0;
                e.f3   = s.instr[14:12];
                e.f7b5 = s.instr[30];
                e.cls  = r.cls;
                e.ill  = r.ill;
                sb.push_back(e);
                void'(slot_q.pop_front());
            end
            m_id_valid = adv ? 1'b1 : (id_ready ? 1'b0 : m_id_valid);
            if (if_valid && exp_if_ready) slot_q.push_back('{if_instr, if_pc});
        end
        @(negedge clk);
        #1;
    endtask

    // Monitor: samples between the driver update and the next rising edge.
    initial begin
        exp_t got, held;
        exp_t e;
        bit   hold_pending;
        hold_pending = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                hold_pending = 0;
            end else begin
                got = '{idex.id_pc, idex.id_op1, idex.id_op2, idex.id_imm, idex.id_rd,
                        idex.id_funct3, idex.id_f7b5, idex.id_opclass, idex.id_illegal};
                chk("id_valid", 32'(idex.id_valid), 32'(exp_id_valid));
                chk("if_ready", 32'(if_ready), 32'(exp_if_ready));
                if (hold_pending && idex.id_valid === 1'b1)
                    chk("stable_while_stalled", 32'(got != held), 32'd0);
                if (idex.id_valid === 1'b1 && id_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL txn_unexpected: got pc=%h with no instruction expected", got.pc);
                    end else begin
                        e = sb.pop_front();
                        n_txn++;
                        if (got !== e) begin
                            n_errors++;
                            $display("FAIL txn: got pc=%h op1=%h op2=%h imm=%h rd=%0d f3=%0d f7b5=%0d cls=%0d ill=%0d expected pc=%h op1=%h op2=%h imm=%h rd=%0d f3=%0d f7b5=%0d cls=%0d ill=%0d",
                                     got.pc, got.op1, got.op2, got.imm, got.rd, got.f3, got.f7b5, got.cls, got.ill,
                                     e.pc, e.op1, e.op2, e.imm, e.rd, e.f3, e.f7b5, e.cls, e.ill);
                        end else begin
                            $display("txn %0d pc=%h op1=%h op2=%h imm=%h rd=%0d cls=%0d ill=%0d ok",
                                     n_txn, got.pc, got.op1, got.op2, got.imm, got.rd, got.cls, got.ill);
                        end
                    end
                end
                hold_pending = (idex.id_valid === 1'b1) && !id_ready;
                held = got;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; id_ready = 0;
        ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_result = 0;
        wb_rd = 0; wb_wen = 0; wb_data = 0;
        rf_mem[0] = 0;
        for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
        @(negedge clk);
        #1;
        step();
        step();
        rst = 0;

        chk("rst_id_valid", 32'(idex.id_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_id_pc", idex.id_pc, TB_RST_PC);
        chk("rst_id_op1", idex.id_op1, 32'd0);
        chk("rst_id_op2", idex.id_op2, 32'd0);
        chk("rst_id_imm", idex.id_imm, 32'd0);
        chk("rst_id_rd", 32'(idex.id_rd), 32'd0);
        chk("rst_id_funct3", 32'(idex.id_funct3), 32'd0);
        chk("rst_id_f7b5", 32'(idex.id_f7b5), 32'd0);
        chk("rst_id_opclass", 32'(idex.id_opclass), 32'd0);
        chk("rst_id_illegal", 32'(idex.id_illegal), 32'd0);
        mon_en = 1;

        // addi x1,x0,5
        id_ready = 1; if_valid = 1; if_instr = 32'h0050_0093; if_pc = 32'h40; step();
        if_valid = 0; step(); step();

        // add x4,x3,x3 with x3 in execute
        if_valid = 1; if_instr = 32'h0031_8233; if_pc = 32'h44; step();
        if_valid = 0; ex_rd = 3; ex_wen = 1; ex_result = 32'hAA; step(); step();
        ex_wen = 0; step(); step();

        // sub x6,x5,x2 behind a load of x5
        if_valid = 1; if_instr = 32'h4022_8333; if_pc = 32'h48; step();
        if_valid = 0; ex_is_load = 1; ex_wen = 1; ex_rd = 5; step();
        ex_is_load = 0; ex_wen = 0; wb_wen = 1; wb_rd = 5; wb_data = 32'h55; step();
        wb_wen = 0; step(); step();

        // execute back-pressure with fetch still offering
        id_ready = 1; if_valid = 1; if_instr = rand_instr(); if_pc = 32'h50; step();
        id_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if_instr = rand_instr(); if_pc = 32'h54 + 32'(4 * i); step();
        end
        if_valid = 0; id_ready = 1; step(); step(); step();

        // flush alongside a fetch offer, with the ID/EX register occupied
        if_valid = 1; if_instr = 32'h0050_0093; if_pc = 32'h70; step();
        if_instr = 32'h0031_8233; if_pc = 32'h74; step();
        id_ready = 0; if_instr = 32'h0010_0093; if_pc = 32'h78; flush = 1; step();
        flush = 0; if_valid = 0; id_ready = 1; step(); step();

        // beq imm=-4, then an illegal opcode
        if_valid = 1; if_instr = 32'hFE00_0EE3; if_pc = 32'h80; step();
        if_instr = 32'h0000_007F; if_pc = 32'h84; step();
        if_valid = 0; step(); step();

        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = !rst && ($urandom_range(0, 24) == 0);
            if_valid   = ($urandom_range(0, 3) != 0);
            if_instr   = rand_instr();
            if_pc      = $urandom & 32'hFFFF_FFFC;
            id_ready   = !rst && !flush && ($urandom_range(0, 3) != 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_wen     = ($urandom_range(0, 2) == 0);
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_result  = $urandom;
            wb_rd      = 5'($urandom_range(0, 7));
            wb_wen     = ($urandom_range(0, 2) == 0);
            wb_data    = $urandom;
            rf_mem[$urandom_range(1, 31)] = $urandom;
            step();
        end

        rst = 0; flush = 0; if_valid = 0; id_ready = 1;
        ex_wen = 0; ex_is_load = 0; wb_wen = 0;
        for (int i = 0; i < 6; i++) step();
        chk("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("drain_slot_empty", 32'(slot_q.size()), 32'd0);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
